// File: rtl/waveform_plot.sv
// Raster-synchronous plotter for the scope's integrator/comparator capture buffers,
// plus the once-per-frame capture bank commit strobe issued at the start of vertical blanking.
module waveform_plot #(
    parameter int          H_ACTIVE   = 1024,
    parameter int          V_ACTIVE   = 768,
    parameter int          RD_LAT     = 2,
    parameter logic [11:0] INT_COLOR  = 12'h0F0,
    parameter logic [11:0] CMP_COLOR  = 12'hFF0,
    parameter logic [11:0] GRID_COLOR = 12'h444
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic        freeze,
    input  logic [9:0]  integrator_dout,
    input  logic [9:0]  comparator_dout,
    output logic [9:0]  waveform_addr,
    output logic        can_commit,
    output logic [11:0] pixel,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    localparam int          DLY   = RD_LAT + 1;
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);
    localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  V_MID = 10'(V_ACTIVE / 2);

    typedef enum logic {
        ACTIVE,
        VBLANK
    } state_t;

    // ------------------------------------------------------------------
    // S0: sample read address
    // ------------------------------------------------------------------
    logic [9:0] addr_d, addr_q;

    always_comb begin
        addr_d = (hcount < H_LIM) ? hcount[9:0] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign waveform_addr = addr_q;

    // ------------------------------------------------------------------
    // Raster delay line, aligned with returned sample data
    // ------------------------------------------------------------------
    logic [10:0] hcnt_dly_q [DLY];
    logic [9:0]  vcnt_dly_q [DLY];
    logic        hs_dly_q   [DLY];
    logic        vs_dly_q   [DLY];
    logic        bl_dly_q   [DLY];

    // NOTE: the delay line is small flop storage, not RAM, so it is reset like any other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DLY; i++) begin
                hcnt_dly_q[i] <= '0;
                vcnt_dly_q[i] <= '0;
                hs_dly_q[i]   <= 1'b0;
                vs_dly_q[i]   <= 1'b0;
                bl_dly_q[i]   <= 1'b0;
            end
        end else begin
            hcnt_dly_q[0] <= hcount;
            vcnt_dly_q[0] <= vcount;
            hs_dly_q[0]   <= hsync;
            vs_dly_q[0]   <= vsync;
            bl_dly_q[0]   <= blank;
            for (int i = 1; i < DLY; i++) begin
                hcnt_dly_q[i] <= hcnt_dly_q[i-1];
                vcnt_dly_q[i] <= vcnt_dly_q[i-1];
                hs_dly_q[i]   <= hs_dly_q[i-1];
                vs_dly_q[i]   <= vs_dly_q[i-1];
                bl_dly_q[i]   <= bl_dly_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: sample-to-row scaling, y = (V_ACTIVE-1) - 3s/4
    // ------------------------------------------------------------------
    logic [11:0] int_prod, cmp_prod;
    logic [9:0]  int_y_d, cmp_y_d;
    logic [9:0]  int_y_q, cmp_y_q;
    logic [10:0] h1_q;
    logic [9:0]  v1_q;
    logic        hs1_q, vs1_q, bl1_q;

    always_comb begin
        int_prod = {2'b00, integrator_dout} * 12'd3;
        cmp_prod = {2'b00, comparator_dout} * 12'd3;
        int_y_d  = Y_MAX - 10'(int_prod >> 2);
        cmp_y_d  = Y_MAX - 10'(cmp_prod >> 2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_y_q <= '0;
            cmp_y_q <= '0;
            h1_q    <= '0;
            v1_q    <= '0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            bl1_q   <= 1'b0;
        end else begin
            int_y_q <= int_y_d;
            cmp_y_q <= cmp_y_d;
            h1_q    <= hcnt_dly_q[DLY-1];
            v1_q    <= vcnt_dly_q[DLY-1];
            hs1_q   <= hs_dly_q[DLY-1];
            vs1_q   <= vs_dly_q[DLY-1];
            bl1_q   <= bl_dly_q[DLY-1];
        end
    end

    // ------------------------------------------------------------------
    // Trace continuity: light every row between the previous and current y
    // ------------------------------------------------------------------
    function automatic logic in_span(input logic [9:0] a, input logic [9:0] b,
                                     input logic [9:0] v);
        logic [9:0] lo;
        logic [9:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return (v >= lo) && (v <= hi);
    endfunction

    logic [9:0] int_prev_q, cmp_prev_q;
    logic [9:0] int_prev, cmp_prev;
    logic       int_lit, cmp_lit;

    // Column 0 anchors to its own y so no segment wraps in from the previous line.
    always_comb begin
        int_prev = (h1_q == 11'd0) ? int_y_q : int_prev_q;
        cmp_prev = (h1_q == 11'd0) ? cmp_y_q : cmp_prev_q;
        int_lit  = in_span(int_prev, int_y_q, v1_q);
        cmp_lit  = in_span(cmp_prev, cmp_y_q, v1_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_prev_q <= '0;
            cmp_prev_q <= '0;
        end else if (h1_q < H_LIM) begin
            int_prev_q <= int_y_q;
            cmp_prev_q <= cmp_y_q;
        end
    end

    // ------------------------------------------------------------------
    // S2: pixel compose and aligned timing outputs
    // ------------------------------------------------------------------
    logic [11:0] pixel_d, pixel_q;
    logic        hsync_q, vsync_q, blank_q;

    // NOTE: pixel_d gets a default before the priority chain so no latch is inferred.
    always_comb begin
        pixel_d = '0;
        if (bl1_q) begin
            pixel_d = '0;
        end else if (cmp_lit) begin
            pixel_d = CMP_COLOR;
        end else if (int_lit) begin
            pixel_d = INT_COLOR;
        end else if ((v1_q == V_MID) || (h1_q[6:0] == 7'd0)) begin
            pixel_d = GRID_COLOR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_q <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            pixel_q <= pixel_d;
            hsync_q <= hs1_q;
            vsync_q <= vs1_q;
            blank_q <= bl1_q;
        end
    end

    assign pixel     = pixel_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign blank_out = blank_q;

    // ------------------------------------------------------------------
    // Commit FSM: one pulse on each active -> vertical-blank transition
    // ------------------------------------------------------------------
    state_t state_q;
    logic   commit_q;

    // Starting in VBLANK keeps a reset during blanking from issuing a late mid-frame swap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= VBLANK;
            commit_q <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            case (state_q)
                ACTIVE: begin
                    if (vcount >= V_LIM) begin
                        state_q  <= VBLANK;
                        commit_q <= !freeze;
                    end
                end
                VBLANK: begin
                    if (vcount < V_LIM) begin
                        state_q <= ACTIVE;
                    end
                end
                default: state_q <= VBLANK;
            endcase
        end
    end

    assign can_commit = commit_q;

endmodule

// File: tb/tb_waveform_plot.sv
// Directed bench for waveform_plot: trace drawing, graticule, pipeline latency and commit strobe.
module tb_waveform_plot;

    localparam logic [11:0] INT_C  = 12'h0F0;
    localparam logic [11:0] CMP_C  = 12'hFF0;
    localparam logic [11:0] GRID_C = 12'h444;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync, vsync, blank, freeze;

    logic [9:0]  int_dout0, cmp_dout0, int_rd0, cmp_rd0;
    logic [9:0]  int_dout1, cmp_dout1;
    logic [9:0]  addr0, addr1;
    logic        commit0, commit1;
    logic [11:0] pixel0, pixel1;
    logic        hs_out0, vs_out0, bl_out0;
    logic        hs_out1, vs_out1, bl_out1;

    logic [9:0]  int_mem [1024];
    logic [9:0]  cmp_mem [1024];
    logic [11:0] obs [1024];

    int n_vec = 0;
    int n_bad = 0;
    int last_v = 0;
    int pulses, good;

    always #5 clk = ~clk;

    waveform_plot dut0 (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .freeze(freeze),
        .integrator_dout(int_dout0), .comparator_dout(cmp_dout0),
        .waveform_addr(addr0), .can_commit(commit0), .pixel(pixel0),
        .hsync_out(hs_out0), .vsync_out(vs_out0), .blank_out(bl_out0)
    );

    waveform_plot #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .freeze(freeze),
        .integrator_dout(int_dout1), .comparator_dout(cmp_dout1),
        .waveform_addr(addr1), .can_commit(commit1), .pixel(pixel1),
        .hsync_out(hs_out1), .vsync_out(vs_out1), .blank_out(bl_out1)
    );

    // Capture buffer models: two-cycle read for dut0, one-cycle read for dut1.
    always @(posedge clk) begin
        int_rd0   <= int_mem[addr0];
        cmp_rd0   <= cmp_mem[addr0];
        int_dout0 <= int_rd0;
        cmp_dout0 <= cmp_rd0;
        int_dout1 <= int_mem[addr1];
        cmp_dout1 <= cmp_mem[addr1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [9:0] iv, input logic [9:0] cv);
        for (int i = 0; i < 1024; i++) begin
            int_mem[i] = iv;
            cmp_mem[i] = cv;
        end
    endtask

    task automatic idle();
        hcount = 11'd1100;
        blank  = 1'b1;
        hsync  = 1'b0;
        vsync  = 1'b0;
    endtask

    // Drive n active columns of line v, then collect dut0 pixels (5-cycle latency) into obs[].
    task automatic sweep(input int v, input int first, input int n);
        for (int i = 0; i < n + 5; i++) begin
            @(posedge clk); #1;
            if (i >= 5) obs[first + i - 5] = pixel0;
            if (i < n) begin
                hcount = 11'(first + i);
                vcount = 10'(v);
                blank  = 1'b0;
            end else begin
                idle();
            end
        end
    endtask

    // Step vcount one line per cycle; count strobes and those landing right after line 768.
    // fmode: 0 freeze low, 1 freeze high, 2 freeze low only while line 768 is driven.
    task automatic run_rows(input int v_from, input int v_to, input int fmode,
                            output int n_pulse, output int n_good);
        n_pulse = 0;
        n_good  = 0;
        for (int v = v_from; v <= v_to + 1; v++) begin
            @(posedge clk); #1;
            if (commit0) begin
                n_pulse++;
                if (last_v == 768) n_good++;
            end
            if (v <= v_to) begin
                vcount = 10'(v);
                freeze = (fmode == 0) ? 1'b0 : (fmode == 1) ? 1'b1 : (v != 768);
                last_v = v;
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        freeze = 1'b0;
        vcount = 10'd0;
        idle();
        fill(10'd0, 10'd0);
        repeat (4) @(posedge clk);
        #1;
        check("rst pixel", pixel0, 12'h000);
        check("rst blank_out", bl_out0, 1'b1);
        check("rst hsync_out", hs_out0, 1'b0);
        check("rst vsync_out", vs_out0, 1'b0);
        check("rst addr", addr0, 10'd0);
        check("rst can_commit", commit0, 1'b0);
        check("rst blank_out lat1", bl_out1, 1'b1);
        check("rst can_commit lat1", commit1, 1'b0);
        reset = 1'b1;
        repeat (6) @(posedge clk);

        // Graticule-only line at the vertical centre
        sweep(384, 0, 8);
        for (int c = 0; c < 8; c++) check($sformatf("grid384 col%0d", c), obs[c], GRID_C);

        // Latency: one active pixel with hsync/vsync marked, both read latencies
        @(posedge clk); #1;
        hcount = 11'd5; vcount = 10'd384; blank = 1'b0; hsync = 1'b1; vsync = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk); #1;
            if (j == 1) idle();
            if (j == 3) check("lat1 early pixel", pixel1, 12'h000);
            if (j == 4) begin
                check("lat1 pixel", pixel1, GRID_C);
                check("lat1 hsync_out", hs_out1, 1'b1);
                check("lat1 vsync_out", vs_out1, 1'b1);
                check("lat1 blank_out", bl_out1, 1'b0);
                check("lat2 early pixel", pixel0, 12'h000);
                check("lat2 early hsync_out", hs_out0, 1'b0);
                check("lat2 early blank_out", bl_out0, 1'b1);
            end
            if (j == 5) begin
                check("lat2 pixel", pixel0, GRID_C);
                check("lat2 hsync_out", hs_out0, 1'b1);
                check("lat2 vsync_out", vs_out0, 1'b1);
                check("lat2 blank_out", bl_out0, 1'b0);
                check("lat1 late hsync_out", hs_out1, 1'b0);
            end
            if (j == 6) begin
                check("lat2 late pixel", pixel0, 12'h000);
                check("lat2 late hsync_out", hs_out0, 1'b0);
            end
        end

        // Address stage and wrap-around
        @(posedge clk); #1; hcount = 11'd37;
        @(posedge clk); #1; check("addr 37", addr0, 10'd37);   hcount = 11'd1030;
        @(posedge clk); #1; check("addr 1030", addr0, 10'd0);  hcount = 11'd1023;
        @(posedge clk); #1; check("addr 1023", addr0, 10'd1023); hcount = 11'd1024;
        @(posedge clk); #1; check("addr 1024", addr0, 10'd0);  idle();

        // Constant samples: integrator 512 -> line 383, comparator 0 -> line 767
        fill(10'd512, 10'd0);
        sweep(383, 0, 1024);
        for (int c = 0; c < 1024; c++) check($sformatf("const383 col%0d", c), obs[c], INT_C);
        sweep(767, 0, 1024);
        for (int c = 0; c < 1024; c++) check($sformatf("const767 col%0d", c), obs[c], CMP_C);
        sweep(384, 0, 1024);
        for (int c = 0; c < 1024; c++) check($sformatf("const384 col%0d", c), obs[c], GRID_C);
        sweep(100, 0, 200);
        check("line100 col0", obs[0], GRID_C);
        check("line100 col1", obs[1], 12'h000);
        check("line100 col64", obs[64], 12'h000);
        check("line100 col128", obs[128], GRID_C);

        // Step: integrator column 10 = 0, column 11 = 1023; comparator parked on line 383
        fill(10'd0, 10'd512);
        int_mem[11] = 10'd1023;
        for (int v = 0; v < 768; v++) begin
            sweep(v, 0, 13);
            check($sformatf("step line%0d col11", v), obs[11], (v == 383) ? CMP_C : INT_C);
            check($sformatf("step line%0d col10", v), obs[10],
                  (v == 383) ? CMP_C : (v == 767) ? INT_C : (v == 384) ? GRID_C : 12'h000);
        end

        // Overlap: comparator wins over integrator on the shared line
        fill(10'd700, 10'd700);
        sweep(242, 0, 1024);
        for (int c = 0; c < 1024; c++) check($sformatf("overlap242 col%0d", c), obs[c], CMP_C);
        sweep(241, 0, 8);
        check("overlap241 col5", obs[5], 12'h000);

        // Reset mid-line
        fill(10'd512, 10'd0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            hcount = 11'(c); vcount = 10'd383; blank = 1'b0;
        end
        @(posedge clk); #1;
        check("pre-reset pixel", pixel0, INT_C);
        #2 reset = 1'b0;
        #1;
        check("midreset pixel", pixel0, 12'h000);
        check("midreset blank_out", bl_out0, 1'b1);
        check("midreset addr", addr0, 10'd0);
        @(posedge clk); #1;
        check("midreset held pixel", pixel0, 12'h000);
        check("midreset held blank_out", bl_out0, 1'b1);
        reset = 1'b1;
        sweep(383, 0, 10);
        check("post-reset col0", obs[0], INT_C);
        check("post-reset col9", obs[9], INT_C);

        // Commit strobe: three frames free-running, then frozen frames
        idle();
        for (int f = 0; f < 3; f++) begin
            run_rows(0, 805, 0, pulses, good);
            check($sformatf("commit f%0d count", f), pulses, 1);
            check($sformatf("commit f%0d timing", f), good, 1);
        end
        for (int f = 0; f < 2; f++) begin
            run_rows(0, 805, 1, pulses, good);
            check($sformatf("freeze f%0d count", f), pulses, 0);
        end
        run_rows(0, 805, 2, pulses, good);
        check("freeze released at 768", good, 1);
        freeze = 1'b0;

        // Reset inside vertical blanking: no strobe until next frame's line 768
        run_rows(0, 770, 0, pulses, good);
        check("blank-reset first frame", good, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        run_rows(771, 805, 0, pulses, good);
        check("blank-reset rest of blank", pulses, 0);
        run_rows(0, 767, 0, pulses, good);
        check("blank-reset active lines", pulses, 0);
        run_rows(768, 805, 0, pulses, good);
        check("blank-reset next count", pulses, 1);
        check("blank-reset next timing", good, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
